instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Upstream neighbour of the 2A03 control unit.
- Loads the reset vector, then fetches the opcode and 0–2 operand bytes per instruction and classifies the addressing mode.
- Hands a complete instruction to control over a valid/ready handshake.
- At instruction boundaries, injects pseudo-BRK for pending NMI/IRQ; accepts PC redirects from control for branches, jumps and vectors.

Parameters:
- RST_VEC, 16'hFFFC, address of reset vector low byte (high byte at RST_VEC+1)
- BRK_OP, 8'h00, opcode presented for an injected interrupt

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mem_addr  out  16  fetch address
- mem_rd  out  1  read strobe; high in every fetch/vector state
- mem_rdata  in  8  read data, combinationally valid in the same cycle as mem_addr
- nmi  in  1  NMI request, rising-edge sensitive
- irq  in  1  IRQ request, level sensitive
- p_i  in  1  interrupt-disable flag from P
- op_valid  out  1  instruction bundle valid
- op_ready  in  1  control consumes bundle
- opcode  out  8  opcode byte
- operand  out  16  {hi,lo}; unused bytes read as 0
- addr_mode  out  4  addressing-mode code (shared package enum)
- op_len  out  2  instruction length, 1..3
- int_src  out  2  0 none, 1 NMI, 2 IRQ, 3 reset-complete marker (never presented)
- illegal  out  1  opcode has cc=11 or is otherwise undefined
- pc_out  out  16  address of byte following the presented instruction
- pc_ld  in  1  redirect request, sampled only on handshake
- pc_new  in  16  redirect target

Behaviour:
- States: RV_LO, RV_HI, OP, OPR1, OPR2, PRESENT. Each fetch state takes exactly one cycle.
- Reset (async, any state) sets:
  - state=RV_LO, PC=0, op_valid=0, opcode=0, operand=0, int_src=0, illegal=0, nmi_pend=0, nmi edge-detect register=0.
  - addr_mode=IMPL, op_len=1.
- RV_LO: mem_addr=RST_VEC; PC[7:0]<=rdata. Next state RV_HI.
- RV_HI: mem_addr=RST_VEC+1; PC[15:8]<=rdata. Next state OP.
- OP, interrupt check:
  - If nmi_pend, or (irq && !p_i): no read (mem_rd=0). Set opcode=BRK_OP, int_src=NMI (priority) else IRQ, op_len=1, PC unchanged. Clear nmi_pend if taken. Next state PRESENT.
  - Otherwise: mem_addr=PC, opcode<=rdata, PC<=PC+1, decode mode/len, operand<=0. Next state OPR1 if len>1, else PRESENT.
- OPR1: operand[7:0]<=rdata, PC++. Next state OPR2 if len=3, else PRESENT.
- OPR2: operand[15:8]<=rdata, PC++. Next state PRESENT.
- PRESENT:
  - op_valid=1; outputs stable until op_valid&&op_ready.
  - On handshake: PC<=pc_ld ? pc_new : PC. Next state OP, with op_valid low for at least one cycle.
  - pc_ld outside a handshake is ignored.
- Decode is split by cc=op[1:0], bbb=op[4:2]:
  - cc=01, by bbb 0..7: INDX, ZP, IMM, ABS, INDY, ZPX, ABSY, ABSX.
  - cc=10, by bbb:
    - 0 IMM; 1 ZP; 2 ACC; 3 ABS; 4 IMPL+illegal.
    - 5 ZPX, or ZPY when op[7:5]∈{4,5}.
    - 6 IMPL.
    - 7 ABSX, or ABSY when op[7:5]=5.
  - cc=00, bbb=0: 00 BRK→IMM (len 2); 20 JSR→ABS; 40/60→IMPL; A0/C0/E0→IMM; 80→IMPL+illegal.
  - cc=00, other bbb: 1 ZP; 2 IMPL; 3 ABS (6C→IND); 4 REL; 5 ZPX; 6 IMPL; 7 ABSX.
  - cc=11: IMPL, len 1, illegal=1.
  - Length: IMPL/ACC=1; IMM/ZP/ZPX/ZPY/INDX/INDY/REL=2; ABS/ABSX/ABSY/IND=3.
- NMI edge detect:
  - nmi_pend sets on a 0→1 transition of nmi, in any state.
  - Set wins over the clear in the same cycle, so a new edge is never lost.
- PC wraps FFFF→0000.
- pc_out = PC, current after the operand bytes.

Decomposition:
- Package cpu_pkg holds:
  - addr_mode_t enum: IMPL, ACC, IMM, ZP, ZPX, ZPY, ABS, ABSX, ABSY, IND, INDX, INDY, REL.
  - int_src_t.
  - RST/NMI/IRQ vector constants.
- Sub-module op_predecode: purely combinational opcode→{addr_mode, op_len, illegal}.

Test Plan:
- Reset with mem[FFFC]=00, mem[FFFD]=80 → PC=8000 after 2 cycles; first OP fetch at 8000.
- mem[8000..8002]=AD 34 12 → bundle opcode=AD, ABS, len=3, operand=1234, pc_out=8003, op_valid on cycle 4 after OP entry.
- Hold op_ready=0 for 5 cycles → bundle stable, no mem_rd. Then op_ready=1 with pc_ld=1, pc_new=9000 → next fetch at 9000.
- irq=1 with p_i=1 → normal fetch. p_i=0 → opcode=00, int_src=IRQ, PC unchanged.
- nmi pulse during OPR1 with irq also pending → next boundary int_src=NMI; a second nmi edge on the take cycle yields a second NMI.
- Assert rst mid-OPR2 → op_valid=0 immediately, restart at RV_LO. Opcode 0x03 → illegal=1, len=1. PC=FFFF with EA → pc_out=0000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 2A03 front end.
//   addr_mode_t   : addressing-mode code carried with every instruction bundle
//   int_src_t     : origin of a presented instruction (normal / NMI / IRQ / reset marker)
//   fetch_state_t : instr_fetch sequencer states, also exported on its debug port
//   *_VEC_ADDR    : interrupt / reset vector low-byte addresses
//   mode_len()    : instruction length in bytes implied by an addressing mode
package cpu_pkg;

   typedef enum logic [3:0] {
      IMPL = 4'd0,
      ACC,
      IMM,
      ZP,
      ZPX,
      ZPY,
      ABS,
      ABSX,
      ABSY,
      IND,
      INDX,
      INDY,
      REL
   } addr_mode_t;

   typedef enum logic [1:0] {
      INT_NONE = 2'd0,
      INT_NMI  = 2'd1,
      INT_IRQ  = 2'd2,
      INT_RST  = 2'd3
   } int_src_t;

   typedef enum logic [2:0] {
      ST_RV_LO   = 3'd0,
      ST_RV_HI   = 3'd1,
      ST_OP      = 3'd2,
      ST_OPR1    = 3'd3,
      ST_OPR2    = 3'd4,
      ST_PRESENT = 3'd5
   } fetch_state_t;

   localparam logic [15:0] NMI_VEC_ADDR = 16'hFFFA;
   localparam logic [15:0] RST_VEC_ADDR = 16'hFFFC;
   localparam logic [15:0] IRQ_VEC_ADDR = 16'hFFFE;
   localparam logic [7:0]  BRK_OPCODE   = 8'h00;

   function automatic logic [1:0] mode_len(input addr_mode_t m);
      case (m)
         IMPL, ACC:            mode_len = 2'd1;
         ABS, ABSX, ABSY, IND: mode_len = 2'd3;
         default:              mode_len = 2'd2;
      endcase
   endfunction

endpackage

// File: rtl/op_predecode.sv
// Combinational opcode classifier.
//   i_op      : opcode byte
//   o_mode    : addressing mode
//   o_len     : instruction length 1..3
//   o_illegal : opcode is undefined (cc=11 or one of the holes in the map)
module op_predecode
   import cpu_pkg::*;
(
   input  logic [7:0] i_op,
   output addr_mode_t o_mode,
   output logic [1:0] o_len,
   output logic       o_illegal
);

   logic [1:0] w_cc;
   logic [2:0] w_bbb;
   logic [2:0] w_aaa;

   assign w_cc  = i_op[1:0];
   assign w_bbb = i_op[4:2];
   assign w_aaa = i_op[7:5];

   always_comb begin
      o_mode    = IMPL;
      o_illegal = 1'b0;
      case (w_cc)
         2'b01: begin
            case (w_bbb)
               3'd0:    o_mode = INDX;
               3'd1:    o_mode = ZP;
               3'd2:    o_mode = IMM;
               3'd3:    o_mode = ABS;
               3'd4:    o_mode = INDY;
               3'd5:    o_mode = ZPX;
               3'd6:    o_mode = ABSY;
               default: o_mode = ABSX;
            endcase
         end
         2'b10: begin
            case (w_bbb)
               3'd0: o_mode = IMM;
               3'd1: o_mode = ZP;
               3'd2: o_mode = ACC;
               3'd3: o_mode = ABS;
               3'd4: begin
                  o_mode    = IMPL;
                  o_illegal = 1'b1;
               end
               // STX/LDX index with Y instead of X
               3'd5:    o_mode = (w_aaa == 3'd4 || w_aaa == 3'd5) ? ZPY : ZPX;
               3'd6:    o_mode = IMPL;
               default: o_mode = (w_aaa == 3'd5) ? ABSY : ABSX;
            endcase
         end
         2'b00: begin
            if (w_bbb == 3'd0) begin
               // column 0 is a mix of BRK/JSR/RTI/RTS and immediates
               case (w_aaa)
                  3'd0:       o_mode = IMM;
                  3'd1:       o_mode = ABS;
                  3'd2, 3'd3: o_mode = IMPL;
                  3'd4: begin
                     o_mode    = IMPL;
                     o_illegal = 1'b1;
                  end
                  default:    o_mode = IMM;
               endcase
            end else begin
               case (w_bbb)
                  3'd1:    o_mode = ZP;
                  3'd2:    o_mode = IMPL;
                  3'd3:    o_mode = (i_op == 8'h6C) ? IND : ABS;
                  3'd4:    o_mode = REL;
                  3'd5:    o_mode = ZPX;
                  3'd6:    o_mode = IMPL;
                  default: o_mode = ABSX;
               endcase
            end
         end
         default: begin
            o_mode    = IMPL;
            o_illegal = 1'b1;
         end
      endcase
   end

   assign o_len = mode_len(o_mode);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch / pre-decode stage feeding the 2A03 control unit.
// Loads the reset vector, fetches opcode + operands, classifies the
// addressing mode and presents the bundle on a valid/ready handshake.
// Pending NMI/IRQ are turned into a pseudo-BRK at instruction boundaries.
//   clk, rst            : clock, async active-high reset
//   mem_addr/rd/rdata   : fetch port (rdata combinational on mem_addr)
//   nmi, irq, p_i       : interrupt requests and the I flag
//   op_valid/op_ready   : bundle handshake
//   opcode .. pc_out    : bundle contents
//   pc_ld, pc_new       : redirect, applied only on the handshake cycle
//   dbg_state           : current sequencer state
//
// Handshake: a bundle is transferred on a rising edge where op_valid and
// op_ready are both high. op_valid stays high and every bundle field stays
// constant until that edge; op_valid then drops for at least one cycle.
module instr_fetch
   import cpu_pkg::*;
#(
   parameter logic [15:0] RST_VEC = RST_VEC_ADDR,
   parameter logic [7:0]  BRK_OP  = BRK_OPCODE
)(
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   input  logic [7:0]  mem_rdata,
   input  logic        nmi,
   input  logic        irq,
   input  logic        p_i,
   output logic        op_valid,
   input  logic        op_ready,
   output logic [7:0]  opcode,
   output logic [15:0] operand,
   output logic [3:0]  addr_mode,
   output logic [1:0]  op_len,
   output logic [1:0]  int_src,
   output logic        illegal,
   output logic [15:0] pc_out,
   input  logic        pc_ld,
   input  logic [15:0] pc_new,
   output logic [2:0]  dbg_state
);

   fetch_state_t r_state;
   fetch_state_t w_state_nxt;

   logic [15:0] r_pc;
   logic [7:0]  r_opcode;
   logic [15:0] r_operand;
   addr_mode_t  r_addr_mode;
   logic [1:0]  r_op_len;
   int_src_t    r_int_src;
   logic        r_illegal;
   logic        r_nmi_q;
   logic        r_nmi_pend;

   addr_mode_t  w_dec_mode;
   logic [1:0]  w_dec_len;
   logic        w_dec_ill;
   logic        w_nmi_edge;
   logic        w_take_int;
   logic        w_handshake;

   op_predecode u_predecode (
      .i_op      (mem_rdata),
      .o_mode    (w_dec_mode),
      .o_len     (w_dec_len),
      .o_illegal (w_dec_ill)
   );

   assign w_nmi_edge  = nmi & ~r_nmi_q;
   assign w_take_int  = r_nmi_pend | (irq & ~p_i);
   assign w_handshake = (r_state == ST_PRESENT) & op_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_RV_LO;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      mem_addr    = r_pc;
      mem_rd      = 1'b0;
      op_valid    = 1'b0;
      case (r_state)
         ST_RV_LO: begin
            mem_addr    = RST_VEC;
            mem_rd      = 1'b1;
            w_state_nxt = ST_RV_HI;
         end
         ST_RV_HI: begin
            mem_addr    = RST_VEC + 16'd1;
            mem_rd      = 1'b1;
            w_state_nxt = ST_OP;
         end
         ST_OP: begin
            // an injected interrupt replaces the opcode read entirely
            mem_rd      = ~w_take_int;
            if (w_take_int)            w_state_nxt = ST_PRESENT;
            else if (w_dec_len > 2'd1) w_state_nxt = ST_OPR1;
            else                       w_state_nxt = ST_PRESENT;
         end
         ST_OPR1: begin
            mem_rd      = 1'b1;
            w_state_nxt = (r_op_len == 2'd3) ? ST_OPR2 : ST_PRESENT;
         end
         ST_OPR2: begin
            mem_rd      = 1'b1;
            w_state_nxt = ST_PRESENT;
         end
         ST_PRESENT: begin
            op_valid = 1'b1;
            if (w_handshake) w_state_nxt = ST_OP;
         end
         default: w_state_nxt = ST_RV_LO;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc        <= 16'h0000;
         r_opcode    <= 8'h00;
         r_operand   <= 16'h0000;
         r_addr_mode <= IMPL;
         r_op_len    <= 2'd1;
         r_int_src   <= INT_NONE;
         r_illegal   <= 1'b0;
         r_nmi_q     <= 1'b0;
         r_nmi_pend  <= 1'b0;
      end else begin
         r_nmi_q <= nmi;
         // a fresh edge outranks the clear so back-to-back NMIs survive
         if (w_nmi_edge)                              r_nmi_pend <= 1'b1;
         else if (r_state == ST_OP && r_nmi_pend)     r_nmi_pend <= 1'b0;

         case (r_state)
            ST_RV_LO: r_pc[7:0]  <= mem_rdata;
            ST_RV_HI: r_pc[15:8] <= mem_rdata;
            ST_OP: begin
               r_operand <= 16'h0000;
               if (w_take_int) begin
                  r_opcode    <= BRK_OP;
                  r_addr_mode <= IMPL;
                  r_op_len    <= 2'd1;
                  r_illegal   <= 1'b0;
                  r_int_src   <= r_nmi_pend ? INT_NMI : INT_IRQ;
               end else begin
                  r_opcode    <= mem_rdata;
                  r_addr_mode <= w_dec_mode;
                  r_op_len    <= w_dec_len;
                  r_illegal   <= w_dec_ill;
                  r_int_src   <= INT_NONE;
                  r_pc        <= r_pc + 16'd1;
               end
            end
            ST_OPR1: begin
               r_operand[7:0] <= mem_rdata;
               r_pc           <= r_pc + 16'd1;
            end
            ST_OPR2: begin
               r_operand[15:8] <= mem_rdata;
               r_pc            <= r_pc + 16'd1;
            end
            ST_PRESENT: begin
               if (w_handshake && pc_ld) r_pc <= pc_new;
            end
            default: ;
         endcase
      end
   end

   assign opcode    = r_opcode;
   assign operand   = r_operand;
   assign addr_mode = r_addr_mode;
   assign op_len    = r_op_len;
   assign int_src   = r_int_src;
   assign illegal   = r_illegal;
   assign pc_out    = r_pc;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_instr_fetch.sv
`timescale 1ns/1ps
module tb_instr_fetch;
   import cpu_pkg::*;

   localparam int BW = 49;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_rdata;
   logic        nmi, irq, p_i;
   logic        op_valid, op_ready;
   logic [7:0]  opcode;
   logic [15:0] operand;
   logic [3:0]  addr_mode;
   logic [1:0]  op_len;
   logic [1:0]  int_src;
   logic        illegal;
   logic [15:0] pc_out;
   logic        pc_ld;
   logic [15:0] pc_new;
   logic [2:0]  dbg_state;

   logic [7:0] mem [0:65535];
   assign mem_rdata = mem[mem_addr];

   instr_fetch dut (
      .clk(clk), .rst(rst),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
      .nmi(nmi), .irq(irq), .p_i(p_i),
      .op_valid(op_valid), .op_ready(op_ready),
      .opcode(opcode), .operand(operand), .addr_mode(addr_mode),
      .op_len(op_len), .int_src(int_src), .illegal(illegal),
      .pc_out(pc_out), .pc_ld(pc_ld), .pc_new(pc_new),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: run did not complete actual=timeout required=done");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // ---------------- reference model ----------------
   logic [BW-1:0] exp_q[$];
   logic [15:0]   m_pc;

   function automatic logic [3:0] ref_mode(input logic [7:0] op);
      logic [2:0] col;
      col = op[4:2];
      if (op[1:0] == 2'b11) return IMPL;
      case (op)
         8'h00, 8'hA0, 8'hC0, 8'hE0: return IMM;
         8'h20:                      return ABS;
         8'h40, 8'h60, 8'h80:        return IMPL;
         8'h6C:                      return IND;
         8'h96, 8'hB6:               return ZPY;
         8'hBE:                      return ABSY;
         default: ;
      endcase
      if (op[1:0] == 2'b01) begin
         case (col)
            3'd0: return INDX;  3'd1: return ZP;   3'd2: return IMM;  3'd3: return ABS;
            3'd4: return INDY;  3'd5: return ZPX;  3'd6: return ABSY; default: return ABSX;
         endcase
      end
      if (op[1:0] == 2'b10) begin
         case (col)
            3'd0: return IMM;  3'd1: return ZP;  3'd2: return ACC; 3'd3: return ABS;
            3'd5: return ZPX;  3'd7: return ABSX; default: return IMPL;
         endcase
      end
      case (col)
         3'd1: return ZP;  3'd3: return ABS; 3'd4: return REL;
         3'd5: return ZPX; 3'd7: return ABSX; default: return IMPL;
      endcase
   endfunction

   function automatic logic [1:0] ref_len(input logic [3:0] md);
      if (md == IMPL || md == ACC) return 2'd1;
      if (md == ABS || md == ABSX || md == ABSY || md == IND) return 2'd3;
      return 2'd2;
   endfunction

   function automatic logic ref_ill(input logic [7:0] op);
      return (op[1:0] == 2'b11) || (op == 8'h80) || (op[1:0] == 2'b10 && op[4:2] == 3'd4);
   endfunction

   function automatic logic [BW-1:0] pack_b(input logic [7:0] op, input logic [15:0] opr,
                                             input logic [3:0] md, input logic [1:0] ln,
                                             input logic [1:0] src, input logic ill,
                                             input logic [15:0] pc);
      return {op, opr, md, ln, src, ill, pc};
   endfunction

   function automatic logic [BW-1:0] dut_b();
      return pack_b(opcode, operand, addr_mode, op_len, int_src, illegal, pc_out);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // place an instruction at the model PC and queue its expected bundle
   task automatic expect_instr(input logic [7:0] op, input logic [15:0] opr);
      logic [3:0]  md;
      logic [1:0]  ln;
      logic [15:0] a1, a2, ex_opr, nxt;
      md = ref_mode(op);
      ln = ref_len(md);
      a1 = m_pc + 16'd1;
      a2 = m_pc + 16'd2;
      mem[m_pc] = op;
      mem[a1]   = opr[7:0];
      mem[a2]   = opr[15:8];
      if (ln == 2'd1)      ex_opr = 16'h0000;
      else if (ln == 2'd2) ex_opr = {8'h00, opr[7:0]};
      else                 ex_opr = opr;
      nxt = m_pc + {14'd0, ln};
      exp_q.push_back(pack_b(op, ex_opr, md, ln, 2'd0, ref_ill(op), nxt));
      m_pc = nxt;
   endtask

   task automatic expect_int(input logic [1:0] src);
      exp_q.push_back(pack_b(8'h00, 16'h0000, IMPL, 2'd1, src, 1'b0, m_pc));
   endtask

   task automatic check_bundle(input string name, output logic [BW-1:0] e);
      bit ok;
      ok = 1'b0;
      e  = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (op_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (exp_q.size() != 0) e = exp_q.pop_front();
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s op_valid timeout actual=0 required=1", name);
      end else begin
         chk(name, dut_b(), e);
      end
   endtask

   // called at a negedge with op_valid high
   task automatic handshake(input bit ld, input logic [15:0] tgt);
      op_ready = 1'b1;
      pc_ld    = ld;
      pc_new   = tgt;
      @(posedge clk);
      #1;
      op_ready = 1'b0;
      pc_ld    = 1'b0;
      pc_new   = 16'h0000;
      if (ld) m_pc = tgt;
   endtask

   // ---------------- decode vector table ----------------
   typedef struct {
      logic [7:0] op;
      logic [3:0] mode;
      logic [1:0] len;
      logic       ill;
   } vec_t;

   vec_t tbl[16];

   // ---------------- main sequence ----------------
   initial begin
      logic [BW-1:0] e, first_e;
      int  lat;
      bit  iv, pv, ld;

      tbl[0]  = '{8'hAD, ABS,  2'd3, 1'b0};
      tbl[1]  = '{8'h03, IMPL, 2'd1, 1'b1};
      tbl[2]  = '{8'h00, IMM,  2'd2, 1'b0};
      tbl[3]  = '{8'h20, ABS,  2'd3, 1'b0};
      tbl[4]  = '{8'h6C, IND,  2'd3, 1'b0};
      tbl[5]  = '{8'h4C, ABS,  2'd3, 1'b0};
      tbl[6]  = '{8'h80, IMPL, 2'd1, 1'b1};
      tbl[7]  = '{8'h96, ZPY,  2'd2, 1'b0};
      tbl[8]  = '{8'hBE, ABSY, 2'd3, 1'b0};
      tbl[9]  = '{8'h9E, ABSX, 2'd3, 1'b0};
      tbl[10] = '{8'h8A, ACC,  2'd1, 1'b0};
      tbl[11] = '{8'h10, REL,  2'd2, 1'b0};
      tbl[12] = '{8'hA1, INDX, 2'd2, 1'b0};
      tbl[13] = '{8'hB1, INDY, 2'd2, 1'b0};
      tbl[14] = '{8'h89, IMM,  2'd2, 1'b0};
      tbl[15] = '{8'h92, IMPL, 2'd1, 1'b1};

      rst = 1'b1; nmi = 1'b0; irq = 1'b0; p_i = 1'b1;
      op_ready = 1'b0; pc_ld = 1'b0; pc_new = 16'h0000;
      for (int a = 0; a < 65536; a++) mem[a] = 8'hEA;
      mem[16'hFFFC] = 8'h00;
      mem[16'hFFFD] = 8'h80;
      m_pc = 16'h8000;
      expect_instr(8'hAD, 16'h1234);

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_valid", op_valid, 1'b0);
      chk("rst_bundle", dut_b(), pack_b(8'h00, 16'h0000, IMPL, 2'd1, 2'd0, 1'b0, 16'h0000));
      chk("rst_fetch", {mem_rd, mem_addr}, {1'b1, 16'hFFFC});
      chk("rst_state", dbg_state, ST_RV_LO);

      // vector load and first fetch
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk); chk("rv_lo_addr", {mem_rd, mem_addr}, {1'b1, 16'hFFFC});
      @(negedge clk); chk("rv_hi_addr", {mem_rd, mem_addr}, {1'b1, 16'hFFFD});
      @(negedge clk); chk("first_op_fetch", {mem_rd, mem_addr, pc_out}, {1'b1, 16'h8000, 16'h8000});
      lat = 0;
      while (op_valid !== 1'b1 && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      chk("first_latency", lat, 3);
      check_bundle("first_bundle", first_e);

      // stall: bundle frozen, no reads
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("hold_stable", {op_valid, mem_rd, dut_b()}, {1'b1, 1'b0, first_e});
      end
      handshake(1'b1, 16'h9000);

      // decode table, starting at the redirect target
      for (int i = 0; i < 16; i++) begin
         expect_instr(tbl[i].op, 16'($urandom_range(0, 65535)));
         if (i == 0) begin
            @(negedge clk);
            chk("redirect_fetch", {op_valid, mem_rd, mem_addr}, {1'b0, 1'b1, 16'h9000});
         end
         check_bundle("tbl_bundle", e);
         chk("tbl_decode", {addr_mode, op_len, illegal}, {tbl[i].mode, tbl[i].len, tbl[i].ill});
         handshake(1'b0, 16'h0000);
      end

      // IRQ masked, then taken
      irq = 1'b1; p_i = 1'b1;
      expect_instr(8'hA9, 16'h0055);
      check_bundle("irq_masked", e);
      p_i = 1'b0;
      handshake(1'b0, 16'h0000);
      expect_int(INT_IRQ);
      @(negedge clk);
      chk("irq_no_read", mem_rd, 1'b0);
      check_bundle("irq_take", e);
      irq = 1'b0;
      handshake(1'b0, 16'h0000);

      // NMI edge during OPR1 with IRQ also pending; second edge on the take cycle
      expect_instr(8'h8D, 16'h4321);
      @(posedge clk); #1;
      nmi = 1'b1; irq = 1'b1; p_i = 1'b0;
      @(posedge clk); #1;
      nmi = 1'b0;
      check_bundle("nmi_pre", e);
      handshake(1'b0, 16'h0000);
      nmi = 1'b1;
      expect_int(INT_NMI);
      check_bundle("nmi_take1", e);
      handshake(1'b0, 16'h0000);
      expect_int(INT_NMI);
      check_bundle("nmi_take2", e);
      handshake(1'b0, 16'h0000);
      expect_int(INT_IRQ);
      check_bundle("irq_after_nmi", e);
      irq = 1'b0; nmi = 1'b0;
      handshake(1'b1, 16'hFFFF);

      // PC wrap
      expect_instr(8'hEA, 16'h0000);
      check_bundle("wrap_bundle", e);
      chk("wrap_pc", pc_out, 16'h0000);
      handshake(1'b0, 16'h0000);

      // randomized instruction stream with occasional IRQs and redirects
      for (int n = 0; n < 150; n++) begin
         iv = ($urandom_range(0, 3) == 0);
         pv = 1'($urandom_range(0, 1));
         irq = iv; p_i = pv;
         if (iv && !pv) begin
            expect_int(INT_IRQ);
            check_bundle("rand_irq", e);
            irq = 1'b0;
            handshake(1'b0, 16'h0000);
         end
         expect_instr(8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)));
         check_bundle("rand_bundle", e);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         ld = ($urandom_range(0, 7) == 0);
         handshake(ld, 16'($urandom_range(16'h1000, 16'h7000)));
      end
      irq = 1'b0;

      // reset asserted mid-OPR2
      expect_instr(8'hAD, 16'h5678);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("rst_mid_ctrl", {op_valid, mem_rd, mem_addr, pc_out}, {1'b0, 1'b1, 16'hFFFC, 16'h0000});
      chk("rst_mid_bundle", dut_b(), pack_b(8'h00, 16'h0000, IMPL, 2'd1, 2'd0, 1'b0, 16'h0000));
      exp_q.delete();
      m_pc = 16'h8000;
      expect_instr(8'h03, 16'h0000);
      @(posedge clk); #1 rst = 1'b0;
      check_bundle("restart_illegal", e);
      handshake(1'b0, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
